// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared widths, constants and FSM states for the fetch stage
package ifu_fetch_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP  = 32'h0000_0013;
  localparam logic [6:0]             OPCODE_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DISCARD
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - instruction memory req/gnt/rvalid bus between fetch (master) and memory (slave)
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic                   imem_req_o;
  logic [PC_WIDTH-1:0]    imem_addr_o;
  logic                   imem_gnt_i;
  logic                   imem_rvalid_i;
  logic [INSTR_WIDTH-1:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

endinterface

// File: rtl/ifu_fetch_buf.sv
// rtl/ifu_fetch_buf.sv - 2-entry {pc, instr} buffer; entry 0 is always the head
module ifu_fetch_buf
  import ifu_fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_NOP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    push_pc,
  input  logic [INSTR_WIDTH-1:0] push_instr,
  output logic [1:0]             count,
  output logic [PC_WIDTH-1:0]    head_pc,
  output logic [INSTR_WIDTH-1:0] head_instr,
  output logic                   head_valid
);

  logic [PC_WIDTH-1:0]    pc0_q, pc1_q;
  logic [INSTR_WIDTH-1:0] instr0_q, instr1_q;
  logic [1:0]             count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc0_q    <= RESET_PC;
      pc1_q    <= RESET_PC;
      instr0_q <= NOP_INSTR;
      instr1_q <= NOP_INSTR;
      count_q  <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_q    <= push_pc;
            instr0_q <= push_instr;
          end else begin
            pc1_q    <= push_pc;
            instr1_q <= push_instr;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          // Popping the last entry leaves entry 0 untouched so if_pc_o holds steady.
          if (count_q == 2'd2) begin
            pc0_q    <= pc1_q;
            instr0_q <= instr1_q;
          end
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            pc0_q    <= push_pc;
            instr0_q <= push_instr;
          end else begin
            pc0_q    <= pc1_q;
            instr0_q <= instr1_q;
            pc1_q    <= push_pc;
            instr1_q <= push_instr;
          end
        end
        default: ;
      endcase
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_pc    = pc0_q;
  assign head_instr = head_valid ? instr0_q : NOP_INSTR;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: PC generation, imem handshake, 2-deep buffer, redirect
// Optional JAL predecode of the next fetch address is enabled by defining IFU_JAL_PREDECODE_EN.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_NOP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  ifu_fetch_if.master            imem,
  output logic [PC_WIDTH-1:0]    if_pc_o,
  output logic [INSTR_WIDTH-1:0] if_instr_o,
  output logic                   if_valid_o
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] next_pc;
  logic [1:0]          buf_count;
  logic [1:0]          count_after;
  logic                buf_push, buf_pop;

  // Redirect overrides push and pop; the flush empties the buffer instead.
  assign buf_pop     = if_valid_o && !stall_i && !redirect_i;
  assign buf_push    = (state_q == ST_WAIT) && imem.imem_rvalid_i && !redirect_i;
  assign count_after = buf_count + {1'b0, buf_push} - {1'b0, buf_pop};

`ifdef IFU_JAL_PREDECODE_EN
  logic [PC_WIDTH-1:0] jal_offset;
  assign jal_offset = {{(PC_WIDTH-20){imem.imem_rdata_i[31]}}, imem.imem_rdata_i[19:12],
                       imem.imem_rdata_i[20], imem.imem_rdata_i[30:21], 1'b0};
  assign next_pc = (imem.imem_rdata_i[6:0] == OPCODE_JAL) ? fetch_pc_q + jal_offset
                                                          : fetch_pc_q + PC_WIDTH'(4);
`else
  assign next_pc = fetch_pc_q + PC_WIDTH'(4);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      // Nothing is outstanding in IDLE, so the space check reduces to the buffer count.
      ST_IDLE: begin
        if (redirect_i || (buf_count < 2'd2)) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_i)              state_d = imem.imem_gnt_i ? ST_DISCARD : ST_IDLE;
        else if (imem.imem_gnt_i)    state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_i) begin
          state_d = imem.imem_rvalid_i ? ST_REQ : ST_DISCARD;
        end else if (imem.imem_rvalid_i) begin
          fetch_pc_d = next_pc;
          state_d    = (count_after < 2'd2) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (imem.imem_rvalid_i) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect_i) fetch_pc_d = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
  end

  assign imem.imem_req_o  = (state_q == ST_REQ);
  assign imem.imem_addr_o = fetch_pc_q;

  ifu_fetch_buf #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (buf_push),
    .pop        (buf_pop),
    .flush      (redirect_i),
    .push_pc    (fetch_pc_q),
    .push_instr (imem.imem_rdata_i),
    .count      (buf_count),
    .head_pc    (if_pc_o),
    .head_instr (if_instr_o),
    .head_valid (if_valid_o)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized bench for ifu_fetch against a program-order queue model
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_valid_o;

  ifu_fetch_if imem_bus ();

  ifu_fetch #(
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem_bus),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .if_valid_o    (if_valid_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_consumed = 0;
  logic [31:0] model_q[$];
  logic [31:0] exp_req_pc = RST_PC;
  bit          keep = 1'b0;
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_dly = 0;
  int          gnt_hold = 0;
  bit          pend_redir = 1'b0;
  logic [31:0] pend_target = '0;
  bit          prev_req = 1'b0;
  bit          prev_gnt = 1'b0;
  bit          prev_redir = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory image: one JAL (jal x0,+16) at 0x40, otherwise distinct non-branch words.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h0100_006F;
    return {a[26:2] ^ 25'h0A5_A5A5, 7'h13};
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc);
`ifdef IFU_JAL_PREDECODE_EN
    if (pc == 32'h0000_0040) return 32'h0000_0050;
`endif
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(5))
      0:       return 32'h0000_0100;
      1:       return 32'h0000_0203;
      2:       return 32'hFFFF_FFF8;
      3:       return 32'h0000_0040;
      4:       return 32'h0000_003C;
      default: return $urandom;
    endcase
  endfunction

  task automatic cycle(input int gnt_pct, input int stall_pct, input int redir_pct, input int max_dly);
    bit rv, gn;
    @(posedge clk);
    #1;
    stall_i = ($urandom_range(99) < stall_pct);
    if (pend_redir) begin
      redirect_i    = 1'b1;
      redirect_pc_i = pend_target;
      pend_redir    = 1'b0;
    end else begin
      redirect_i    = ($urandom_range(99) < redir_pct);
      redirect_pc_i = pick_target();
    end
    rv = mem_busy && (mem_dly == 0);
    imem_bus.imem_rvalid_i = rv;
    imem_bus.imem_rdata_i  = rv ? mem_word(mem_addr) : $urandom;
    if (gnt_hold > 0) begin
      gn = 1'b0;
      gnt_hold--;
    end else begin
      gn = imem_bus.imem_req_o && !mem_busy && ($urandom_range(99) < gnt_pct);
    end
    imem_bus.imem_gnt_i = gn;

    @(negedge clk);
    check_eq("valid", 32'(if_valid_o), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check_eq("head_pc", if_pc_o, model_q[0]);
      check_eq("head_instr", if_instr_o, mem_word(model_q[0]));
    end else begin
      check_eq("bubble", if_instr_o, NOP);
    end
    if (model_q.size() == 2) check_eq("no_req_full", 32'(imem_bus.imem_req_o), 32'd0);
    if (imem_bus.imem_req_o) begin
      check_eq("req_addr", imem_bus.imem_addr_o, exp_req_pc);
      check_eq("one_outstanding", 32'(mem_busy), 32'd0);
    end
    if (prev_req && !prev_gnt && !prev_redir) begin
      check_eq("req_held", 32'(imem_bus.imem_req_o), 32'd1);
      check_eq("addr_held", imem_bus.imem_addr_o, prev_addr);
    end

    if (model_q.size() != 0 && !stall_i && !redirect_i) begin
      void'(model_q.pop_front());
      n_consumed++;
    end
    if (rv) begin
      if (keep && !redirect_i) model_q.push_back(mem_addr);
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      mem_dly--;
    end
    if (imem_bus.imem_req_o && gn) begin
      mem_busy   = 1'b1;
      mem_addr   = imem_bus.imem_addr_o;
      mem_dly    = $urandom_range(max_dly);
      keep       = 1'b1;
      exp_req_pc = model_next(imem_bus.imem_addr_o);
    end
    if (redirect_i) begin
      model_q.delete();
      keep       = 1'b0;
      exp_req_pc = {redirect_pc_i[31:2], 2'b00};
    end
    prev_req   = imem_bus.imem_req_o;
    prev_gnt   = gn;
    prev_redir = redirect_i;
    prev_addr  = imem_bus.imem_addr_o;
  endtask

  task automatic run(input int n, input int gnt_pct, input int stall_pct, input int redir_pct,
                     input int max_dly);
    for (int i = 0; i < n; i++) cycle(gnt_pct, stall_pct, redir_pct, max_dly);
  endtask

  // Optionally leaves a stale rvalid on the bus in the first cycle after release.
  task automatic do_reset(input bit stale);
    @(posedge clk);
    #1;
    rst_n                  = 1'b0;
    stall_i                = 1'b0;
    redirect_i             = 1'b0;
    imem_bus.imem_gnt_i    = 1'b0;
    imem_bus.imem_rvalid_i = 1'b0;
    #1;
    check_eq("rst_req", 32'(imem_bus.imem_req_o), 32'd0);
    check_eq("rst_addr", imem_bus.imem_addr_o, RST_PC);
    check_eq("rst_valid", 32'(if_valid_o), 32'd0);
    check_eq("rst_instr", if_instr_o, NOP);
    check_eq("rst_pc", if_pc_o, RST_PC);
    model_q.delete();
    keep        = 1'b0;
    exp_req_pc  = RST_PC;
    prev_req    = 1'b0;
    gnt_hold    = 0;
    pend_redir  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if (stale && mem_busy) begin
      imem_bus.imem_rvalid_i = 1'b1;
      imem_bus.imem_rdata_i  = $urandom;
    end
    mem_busy = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    pend_redir  = 1'b1;
    pend_target = target;
  endtask

  initial begin
    imem_bus.imem_gnt_i    = 1'b0;
    imem_bus.imem_rvalid_i = 1'b0;
    imem_bus.imem_rdata_i  = '0;
    do_reset(1'b0);

    run(30, 100, 0, 0, 0);
    run(6, 100, 100, 0, 1);
    run(15, 100, 0, 0, 1);
    redirect_to(32'h0000_0100);
    run(12, 100, 0, 0, 0);
    redirect_to(32'h0000_0203);
    gnt_hold = 5;
    run(14, 100, 0, 0, 0);
    redirect_to(32'hFFFF_FFF8);
    run(12, 100, 20, 0, 1);
    redirect_to(32'h0000_0040);
    run(12, 100, 0, 0, 0);
    redirect_to(32'h0000_0038);
    run(16, 60, 30, 0, 2);

    for (int blk = 0; blk < 8; blk++) begin
      run(500, 40 + 8 * blk, 10 * (blk % 4), 2 + (blk % 3), blk % 4);
      do_reset(1'b1);
    end
    run(40, 100, 0, 0, 0);

    check_eq("progress", 32'(n_consumed > 300), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
